// File: rtl/tt_um_muncherkin_lioncage.sv
// Lion-cage toy: a lion paces around segments a..f, escapes through an open door,
// munches when fed and can be recaptured; munch/escape tallies appear on uio_out.
module tt_um_muncherkin_lioncage (
    input  logic       clk,
    input  logic       rst_n,    // active-high asynchronous reset despite the name
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        PACE,
        MUNCH,
        ESCAPED
    } state_t;

    localparam logic [2:0] POS_LAST  = 3'd5;
    localparam logic [2:0] MTICK_END = 3'd7;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_G     = 7'b1000000;

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  mtick_q, mtick_d;
    logic [3:0]  munch_cnt_q, munch_cnt_d;
    logic [3:0]  esc_cnt_q, esc_cnt_d;
    logic [19:0] presc_q;
    logic        feed_prev_q;
    logic        recap_prev_q;
    logic        hb_q;

    logic        door, reverse, feed, recap;
    logic [1:0]  speed;
    logic        tick;
    logic        feed_rise, recap_rise;
    logic [6:0]  seg;

    assign door    = ui_in[0];
    assign reverse = ui_in[1];
    assign feed    = ui_in[2];
    assign recap   = ui_in[3];
    assign speed   = ui_in[7:6];

    assign feed_rise  = feed & ~feed_prev_q;
    assign recap_rise = recap & ~recap_prev_q;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[5:4]};

    // Tick fires when the prescaler's low bits roll over; changing speed just
    // picks a different slice of the same free-running count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        tick = 1'b0;
        case (speed)
            2'b00:   tick = 1'b1;
            2'b01:   tick = &presc_q[7:0];
            2'b10:   tick = &presc_q[15:0];
            default: tick = &presc_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        mtick_d     = mtick_q;
        munch_cnt_d = munch_cnt_q;
        esc_cnt_d   = esc_cnt_q;

        case (state_q)
            PACE: begin
                // Escape outranks a same-cycle feed edge; feeding freezes the lion.
                if (tick && door && pos_q == 3'd0) begin
                    state_d = ESCAPED;
                    if (esc_cnt_q != 4'hF)
                        esc_cnt_d = esc_cnt_q + 4'd1;
                end else if (feed_rise) begin
                    state_d     = MUNCH;
                    munch_cnt_d = munch_cnt_q + 4'd1;
                    mtick_d     = 3'd0;
                end else if (tick) begin
                    if (reverse)
                        pos_d = (pos_q == 3'd0) ? POS_LAST : pos_q - 3'd1;
                    else
                        pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
                end
            end

            MUNCH: begin
                if (tick) begin
                    if (mtick_q == MTICK_END)
                        state_d = PACE;
                    else
                        mtick_d = mtick_q + 3'd1;
                end
            end

            ESCAPED: begin
                if (recap_rise && !door) begin
                    state_d = PACE;
                    pos_d   = 3'd0;
                end
            end

            default: state_d = PACE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= PACE;
            pos_q        <= 3'd0;
            mtick_q      <= 3'd0;
            munch_cnt_q  <= 4'd0;
            esc_cnt_q    <= 4'd0;
            presc_q      <= 20'd0;
            feed_prev_q  <= 1'b0;
            recap_prev_q <= 1'b0;
            hb_q         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            pos_q        <= pos_d;
            mtick_q      <= mtick_d;
            munch_cnt_q  <= munch_cnt_d;
            esc_cnt_q    <= esc_cnt_d;
            presc_q      <= presc_q + 20'd1;
            feed_prev_q  <= feed;
            recap_prev_q <= recap;
            hb_q         <= hb_q ^ tick;
        end
    end

    always_comb begin
        seg = 7'd0;
        case (state_q)
            PACE:    seg = 7'b0000001 << pos_q;
            MUNCH:   seg = mtick_q[0] ? 7'd0 : SEG_G;
            ESCAPED: seg = SEG_E;
            default: seg = 7'd0;
        endcase
    end

    assign uo_out  = {hb_q, seg};
    assign uio_out = {munch_cnt_q, esc_cnt_q};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_muncherkin_lioncage.sv
// Self-checking bench for the lion cage: directed scenarios plus randomized
// stimulus compared against a behavioural model of the cage rules.
module tb_tt_um_muncherkin_lioncage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_PACE, M_MUNCH, M_ESC} mode_t;

    mode_t m_mode;
    int    m_pos, m_munches, m_escapes, m_munch_ticks, m_cycles;
    bit    m_hb, m_feed_prev, m_recap_prev;

    tt_um_muncherkin_lioncage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_mode        = M_PACE;
        m_pos         = 0;
        m_munches     = 0;
        m_escapes     = 0;
        m_munch_ticks = 0;
        m_cycles      = 0;
        m_hb          = 1'b0;
        m_feed_prev   = 1'b0;
        m_recap_prev  = 1'b0;
    endtask

    // One rising clock edge of the cage rules, applied with the inputs present at that edge.
    task automatic model_clock(input logic [7:0] ui);
        int shift;
        bit tick, feed_edge, recap_edge;
        case (ui[7:6])
            2'b00:   shift = 0;
            2'b01:   shift = 8;
            2'b10:   shift = 16;
            default: shift = 20;
        endcase
        tick       = ((m_cycles + 1) % (1 << shift)) == 0;
        feed_edge  = ui[2] && !m_feed_prev;
        recap_edge = ui[3] && !m_recap_prev;

        case (m_mode)
            M_PACE: begin
                if (tick && ui[0] && m_pos == 0) begin
                    m_mode    = M_ESC;
                    m_escapes = (m_escapes < 15) ? m_escapes + 1 : 15;
                end else if (feed_edge) begin
                    m_mode        = M_MUNCH;
                    m_munches     = (m_munches + 1) % 16;
                    m_munch_ticks = 0;
                end else if (tick) begin
                    m_pos = ui[1] ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
                end
            end
            M_MUNCH: begin
                if (tick) begin
                    m_munch_ticks++;
                    if (m_munch_ticks == 8) m_mode = M_PACE;
                end
            end
            default: begin
                if (recap_edge && !ui[0]) begin
                    m_mode = M_PACE;
                    m_pos  = 0;
                end
            end
        endcase

        if (tick) m_hb = !m_hb;
        m_feed_prev  = ui[2];
        m_recap_prev = ui[3];
        m_cycles     = (m_cycles + 1) % (1 << 20);
    endtask

    function automatic logic [7:0] exp_uo();
        logic [6:0] seg;
        case (m_mode)
            M_PACE:  seg = 7'(1 << m_pos);
            M_MUNCH: seg = (m_munch_ticks % 2 == 0) ? 7'h40 : 7'h00;
            default: seg = 7'h79;
        endcase
        return {m_hb, seg};
    endfunction

    function automatic logic [7:0] exp_uio();
        return {4'(m_munches), 4'(m_escapes)};
    endfunction

    task automatic do_reset(input logic [7:0] ui);
        ui_in = ui;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic step(input logic [7:0] ui, input string tag);
        ui_in = ui;
        @(posedge clk);
        model_clock(ui);
        #1;
        check({tag, "/uo"}, uo_out, exp_uo());
        check({tag, "/uio"}, uio_out, exp_uio());
    endtask

    // Asserts reset between edges and expects reset values before any clock.
    task automatic mid_reset(input string tag);
        rst_n = 1'b1;
        #1;
        check({tag, "/rst_uo"}, uo_out, 8'h01);
        check({tag, "/rst_uio"}, uio_out, 8'h00);
        check({tag, "/rst_oe"}, uio_oe, 8'hFF);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        logic [7:0] pace_fwd [7];
        logic [7:0] pace_rev [6];
        logic [7:0] munch_seq [7];
        logic [7:0] ui;
        int         speed_pick;

        pace_fwd  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01, 8'h02};
        pace_rev  = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        munch_seq = '{8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00};
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst_n  = 1'b1;

        // Reset values
        #2;
        check("reset_uo", uo_out, 8'h01);
        check("reset_uio", uio_out, 8'h00);
        check("reset_oe", uio_oe, 8'hFF);

        // Forward pacing at full speed with heartbeat alternating
        do_reset(8'h00);
        for (int k = 0; k < 7; k++) begin
            step(8'h00, "fwd");
            check("fwd_seq", uo_out, {((k % 2) == 0) ? 1'b1 : 1'b0, pace_fwd[k][6:0]});
        end

        // Reverse pacing
        do_reset(8'h02);
        for (int k = 0; k < 6; k++) begin
            step(8'h02, "rev");
            check("rev_seq", {1'b0, uo_out[6:0]}, pace_rev[k]);
        end

        // Escape on first tick, then recapture
        do_reset(8'h01);
        step(8'h01, "esc");
        check("esc_seg", {1'b0, uo_out[6:0]}, 8'h79);
        check("esc_uio", uio_out, 8'h01);
        step(8'h00, "esc_hold");
        check("esc_hold_seg", {1'b0, uo_out[6:0]}, 8'h79);
        step(8'h08, "recap");
        check("recap_seg", {1'b0, uo_out[6:0]}, 8'h01);
        step(8'h00, "recap_pace");
        check("recap_pace_seg", {1'b0, uo_out[6:0]}, 8'h02);

        // Recapture with door still open is ignored
        step(8'h00, "to_pos2");
        for (int k = 0; k < 4; k++) step(8'h00, "to_pos0");
        step(8'h01, "esc2");
        step(8'h09, "recap_door_open");
        check("recap_door_open_seg", {1'b0, uo_out[6:0]}, 8'h79);

        // Feed at pos 2: munch animation then resume from pos 2
        do_reset(8'h00);
        step(8'h00, "feed_pre");
        step(8'h00, "feed_pre");
        check("feed_pos2", {1'b0, uo_out[6:0]}, 8'h04);
        step(8'h04, "feed");
        check("feed_seg", {1'b0, uo_out[6:0]}, 8'h40);
        check("feed_count", {4'h0, uio_out[7:4]}, 8'h01);
        for (int k = 0; k < 7; k++) begin
            step(8'h07, "munch");
            check("munch_seq", {1'b0, uo_out[6:0]}, munch_seq[k]);
        end
        step(8'h00, "munch_done");
        check("munch_done_seg", {1'b0, uo_out[6:0]}, 8'h04);
        step(8'h00, "munch_resume");
        check("munch_resume_seg", {1'b0, uo_out[6:0]}, 8'h08);

        // Escape counter saturates at 15
        do_reset(8'h00);
        for (int i = 1; i <= 17; i++) begin
            step(8'h01, "sat_esc");
            check("sat_count", {4'h0, uio_out[3:0]}, 8'((i < 15) ? i : 15));
            step(8'h08, "sat_recap");
        end
        check("sat_final", {4'h0, uio_out[3:0]}, 8'h0F);

        // Speed 01: one move per 256 clocks, then reset during munch
        do_reset(8'h40);
        for (int k = 0; k < 255; k++) step(8'h40, "slow");
        check("slow_hold", {1'b0, uo_out[6:0]}, 8'h01);
        step(8'h40, "slow_tick");
        check("slow_move", {1'b0, uo_out[6:0]}, 8'h02);
        step(8'h44, "slow_feed");
        check("slow_feed_seg", {1'b0, uo_out[6:0]}, 8'h40);
        for (int k = 0; k < 10; k++) step(8'h40, "slow_munch");
        mid_reset("mid_munch");
        step(8'h00, "post_rst");
        check("post_rst_seg", {1'b0, uo_out[6:0]}, 8'h02);

        // Randomized stimulus against the model, with occasional async resets
        do_reset(8'h00);
        for (int n = 0; n < 3000; n++) begin
            speed_pick = $urandom_range(0, 9);
            ui[7:6] = (speed_pick < 7) ? 2'b00 : (speed_pick < 9) ? 2'b01 : 2'b10;
            ui[5:4] = 2'($urandom);
            ui[3]   = ($urandom_range(0, 3) == 0);
            ui[2]   = ($urandom_range(0, 4) == 0);
            ui[1]   = 1'($urandom);
            ui[0]   = ($urandom_range(0, 3) == 0);
            uio_in  = 8'($urandom);
            step(ui, "rand");
            if ($urandom_range(0, 199) == 0) mid_reset("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_muncherkin_lioncage.md
TT_UM_MUNCHERKIN_LIONCAGE -- requirements
Module: tt_um_muncherkin_lioncage

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high; the polarity applies despite the port name.
REQ-004 ena  input  1  design-select indication; ignored.
REQ-005 ui_in  input  8  controls:
- [0] door open (1 = open)
- [1] reverse direction
- [2] feed
- [3] recapture
- [5:4] unused
- [7:6] speed select
REQ-006 uio_in  input  8  unused.
REQ-007 uo_out  output  8  display:
- [6:0] segments a..g ([0]=a), active-high
- [7] heartbeat (decimal point)
REQ-008 uio_out  output  8  {munch_count[3:0], escape_count[3:0]}.
REQ-009 uio_oe  output  8  constant 8'hFF.

Function
REQ-010 Tick generator SHALL use a free-running 20-bit prescaler.
- Tick period by speed select: 00 = every clock; 01 = 2^8 clocks; 10 = 2^16 clocks; 11 = 2^20 clocks.
- A speed-select change SHALL take effect without resetting the prescaler.
REQ-011 uo_out[7] SHALL toggle on every tick.
REQ-012 The state machine SHALL have exactly three states: PACE, MUNCH, ESCAPED.
REQ-013 PACE: lion position pos (0..5) SHALL map to segments a..f; display = one-hot segment pos, g off.
REQ-014 PACE tick, door=1 and pos=0: SHALL enter ESCAPED instead of advancing.
- escape_count increments, saturating at 15.
REQ-015 PACE tick, no escape: pos advances.
- ui_in[1]=0: pos+1, wrapping 5->0.
- ui_in[1]=1: pos-1, wrapping 0->5.
REQ-016 Feed: rising edge of ui_in[2] (compared against its previous-clock value) sampled in PACE SHALL enter MUNCH on the next clock.
- munch_count increments modulo 16; munch tick counter cleared to 0.
- If the same clock is also a PACE tick meeting the REQ-014 escape condition, escape wins and the feed edge is discarded.
REQ-017 MUNCH: pos frozen; door, reverse and recapture ignored; feed edges ignored.
- Display = segment g only when munch tick counter is even, all segments off when odd.
- Each tick increments the counter; after the 8th tick SHALL return to PACE with unchanged pos.
REQ-018 ESCAPED: display SHALL be 'E' pattern, segments[6:0]=7'b1111001.
- Rising edge of ui_in[3] while ui_in[0]=0 SHALL return to PACE with pos=0.
- A recapture edge with door=1 SHALL be ignored.
REQ-019 Feed edges in ESCAPED SHALL be ignored; the edge detector SHALL still track ui_in[2] so no stale edge fires later.
REQ-020 All outputs SHALL be registered or decoded purely from registered state; no combinational path from ui_in to uo_out.

Reset
REQ-021 While rst_n=1, SHALL immediately clear:
- state=PACE, pos=0
- prescaler, both counters, munch tick counter and edge-detect registers to 0
- heartbeat to 0
REQ-022 Reset outputs SHALL be: uo_out=8'h01, uio_out=8'h00, uio_oe=8'hFF.
REQ-023 Reset asserted mid-MUNCH or mid-ESCAPED SHALL abort that state with no residual effect after release.

Verification
REQ-024 Speed 00, door closed, reverse 0, release reset: uo_out[6:0] per clock = 01,02,04,08,10,20,01; uo_out[7] alternates each clock.
REQ-025 Speed 00, reverse 1 from reset: uo_out[6:0] = 01,20,10,08,04,02,01.
REQ-026 Speed 00, door=1 from reset: first tick enters ESCAPED.
- Expect uo_out[6:0]=7'h79 and uio_out=8'h01.
- Then door=0 plus ui_in[3] 0->1: uo_out[6:0]=01, pacing resumes.
REQ-027 Speed 00, pulse ui_in[2] one clock at pos=2.
- Expect uio_out[7:4]=1; segments alternate 40,00 for 8 ticks.
- Then segments=04 and pacing resumes from pos 2.
REQ-028 Repeat escape/recapture 17 times: uio_out[3:0] stays 4'hF after the 15th escape.
REQ-029 Speed 01: position changes only every 256 clocks; assert rst_n mid-MUNCH -> outputs equal REQ-022 values the same cycle.
